ram_iface_arbiter: RTL
======================

RAM_IFACE_ARBITER -- requirements
Module: ram_iface_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, default 13, line address width; CASH_STR_WIDTH, default 64, cache line width; TIMEOUT_CYCLES, default 255, ack watchdog limit (16-bit, 1..65535).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- not_reset  in  1  asynchronous, active-low reset.
- req0_avalid, req1_avalid  in  1  level request, held until own ack/err.
- req0_addr, req1_addr  in  ADDR_SIZE  line address.
- req0_rnw, req1_rnw  in  1  1=read line, 0=write line.
- req0_wdata, req1_wdata  in  CASH_STR_WIDTH  write line.
- req0_ack, req1_ack  out  1  one-cycle completion pulse.
- req0_err, req1_err  out  1  one-cycle timeout pulse.
- mc_avalid  out  1  one-cycle request pulse to RAM interface controller.
- mc_addr  out  ADDR_SIZE  latched address.
- mc_rnw  out  1  latched direction.
- mc_wdata  out  CASH_STR_WIDTH  latched write line.
- mc_ack  in  1  controller completion pulse (reads and writes).
- owner  out  1  index of granted requester.
- busy  out  1  high whenever state is not S_IDLE.

Function
REQ-003 The FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT, S_RESP; all outputs SHALL be registered.
REQ-004 S_IDLE: if any reqN_avalid is sampled high, the block SHALL select a winner, latch its addr/rnw/wdata into mc_addr/mc_rnw/mc_wdata, set owner, and go to S_ISSUE.
REQ-005 Arbitration SHALL be round-robin: a single requester always wins; on simultaneous requests the port not granted last wins (last_grant register).
REQ-006 S_ISSUE: mc_avalid SHALL be high for exactly one cycle, then S_WAIT; mc_avalid SHALL never be high for two consecutive cycles.
REQ-007 mc_addr, mc_rnw, mc_wdata, owner SHALL stay stable from latch until return to S_IDLE.
REQ-008 S_WAIT: on mc_ack high, req<owner>_ack SHALL pulse one cycle, last_grant <= owner, go S_RESP.
REQ-009 S_RESP: all ack/err outputs SHALL be low; next state S_IDLE unconditionally (one dead cycle for requester to drop avalid).
REQ-010 Latency: request sampled at edge k -> mc_avalid high after edge k+1; mc_ack sampled at edge m -> reqN_ack high after edge m; next arbitration at edge m+2.
REQ-011 mc_ack outside S_WAIT SHALL be ignored.
REQ-012 A requester dropping avalid mid-transaction SHALL NOT abort it; its ack still pulses.
REQ-013 The non-owner port SHALL see no ack/err and its inputs SHALL not affect mc_* outputs.

Reset
REQ-014 On not_reset low, asynchronously: state=S_IDLE; mc_avalid, mc_addr, mc_rnw, mc_wdata, owner, busy, all ack/err = 0; last_grant = 1 (port 0 wins first tie); watchdog counter = 0.
REQ-015 Reset mid-transaction SHALL discard the transaction without ack or err.

Configuration
REQ-016 Macro ARB_TIMEOUT_EN: when defined, a 16-bit counter SHALL clear on S_WAIT entry and increment each S_WAIT cycle; when it reaches TIMEOUT_CYCLES without mc_ack, req<owner>_err SHALL pulse one cycle (no ack), last_grant <= owner, go S_RESP; mc_ack in that same cycle SHALL take precedence (ack, no err).
REQ-017 Without ARB_TIMEOUT_EN: no counter, req0_err/req1_err tied 0, S_WAIT held indefinitely until mc_ack.

Verification
REQ-018 Port 0 read addr 0x0123, mc_ack 10 cycles after mc_avalid -> mc_avalid one cycle, mc_addr=0x0123, mc_rnw=1, req0_ack one pulse, busy low 2 cycles after ack.
REQ-019 Both ports request simultaneously after reset (p0 addr 0x0010 write, p1 addr 0x0020 read) -> p0 served first, then p1; order repeats alternating over 4 back-to-back rounds.
REQ-020 Port 1 write wdata 0xDEADBEEF_CAFEF00D, port 1 changes wdata/addr during S_WAIT -> mc_wdata/mc_addr unchanged until S_IDLE.
REQ-021 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mc_ack -> req<owner>_err pulse 8 cycles after S_WAIT entry, no ack, other port granted next; mc_ack on cycle 8 -> ack only.
REQ-022 not_reset low in S_WAIT, then stray mc_ack after release -> all outputs 0, no ack/err, next request p0 wins tie.

Source files
------------

// File: rtl/ram_iface_arbiter_if.sv
// Bus bundle between two line requesters, the arbiter and the RAM
// interface controller. Signal names match the original flat port list.
interface ram_iface_arbiter_if #(
  parameter int ADDR_SIZE      = 13,
  parameter int CASH_STR_WIDTH = 64
);
  logic                      req0_avalid;
  logic                      req1_avalid;
  logic [ADDR_SIZE-1:0]      req0_addr;
  logic [ADDR_SIZE-1:0]      req1_addr;
  logic                      req0_rnw;
  logic                      req1_rnw;
  logic [CASH_STR_WIDTH-1:0] req0_wdata;
  logic [CASH_STR_WIDTH-1:0] req1_wdata;
  logic                      req0_ack;
  logic                      req1_ack;
  logic                      req0_err;
  logic                      req1_err;
  logic                      mc_avalid;
  logic [ADDR_SIZE-1:0]      mc_addr;
  logic                      mc_rnw;
  logic [CASH_STR_WIDTH-1:0] mc_wdata;
  logic                      mc_ack;
  logic                      owner;
  logic                      busy;

  // Arbiter side
  modport master (
    input  req0_avalid, req1_avalid, req0_addr, req1_addr,
           req0_rnw, req1_rnw, req0_wdata, req1_wdata, mc_ack,
    output req0_ack, req1_ack, req0_err, req1_err,
           mc_avalid, mc_addr, mc_rnw, mc_wdata, owner, busy
  );

  // Requesters and controller side
  modport slave (
    output req0_avalid, req1_avalid, req0_addr, req1_addr,
           req0_rnw, req1_rnw, req0_wdata, req1_wdata, mc_ack,
    input  req0_ack, req1_ack, req0_err, req1_err,
           mc_avalid, mc_addr, mc_rnw, mc_wdata, owner, busy
  );
endinterface

// File: rtl/ram_iface_arbiter.sv
// Two-port round-robin arbiter in front of a RAM interface controller.
// One transaction in flight; all outputs registered.
// Optional macro ARB_TIMEOUT_EN adds an ack watchdog that ends a stalled
// transaction with a one-cycle err pulse after TIMEOUT_CYCLES.
module ram_iface_arbiter #(
  parameter int ADDR_SIZE      = 13,
  parameter int CASH_STR_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                not_reset,
  ram_iface_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]                state;
  logic                      last_grant;
  logic                      win;
  logic [ADDR_SIZE-1:0]      win_addr;
  logic                      win_rnw;
  logic [CASH_STR_WIDTH-1:0] win_wdata;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
`else
  assign bus.req0_err = 1'b0;
  assign bus.req1_err = 1'b0;
`endif

  // Winner select: lone requester wins, on a tie the port not granted last
  always_comb begin
    win       = bus.req1_avalid && (!bus.req0_avalid || !last_grant);
    win_addr  = win ? bus.req1_addr  : bus.req0_addr;
    win_rnw   = win ? bus.req1_rnw   : bus.req0_rnw;
    win_wdata = win ? bus.req1_wdata : bus.req0_wdata;
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state         <= S_IDLE;
      last_grant    <= 1'b1;
      bus.mc_avalid <= 1'b0;
      bus.mc_addr   <= '0;
      bus.mc_rnw    <= 1'b0;
      bus.mc_wdata  <= '0;
      bus.owner     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.req0_ack  <= 1'b0;
      bus.req1_ack  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus.req0_err  <= 1'b0;
      bus.req1_err  <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      bus.mc_avalid <= 1'b0;
      bus.req0_ack  <= 1'b0;
      bus.req1_ack  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus.req0_err  <= 1'b0;
      bus.req1_err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.req0_avalid || bus.req1_avalid) begin
            bus.owner    <= win;
            bus.mc_addr  <= win_addr;
            bus.mc_rnw   <= win_rnw;
            bus.mc_wdata <= win_wdata;
            bus.busy     <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.mc_avalid <= 1'b1;
          state         <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
          wd_cnt        <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.mc_ack) begin
            bus.req0_ack <= !bus.owner;
            bus.req1_ack <= bus.owner;
            last_grant   <= bus.owner;
            state        <= S_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          // mc_ack is tested first so an ack on the final cycle wins over err
          else if (wd_cnt == WD_LAST) begin
            bus.req0_err <= !bus.owner;
            bus.req1_err <= bus.owner;
            last_grant   <= bus.owner;
            state        <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        S_RESP: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
